// File: rtl/module_keypad_scan.sv
// 4x4 matrix-keypad scanner: drives the column index, samples synchronized rows once per
// column dwell, debounces press and release, and reports the key with a one-cycle pulse.
module module_keypad_scan #(
    parameter int SCAN_TICKS  = 27000,
    parameter int DEB_SAMPLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_in,
    output logic [1:0] col_sel,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int TW = $clog2(SCAN_TICKS);
    localparam int DW = $clog2(DEB_SAMPLES + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_SAMPLES);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD, RELEASE} state_t;

    state_t          state, state_nxt;
    logic [3:0]      rows_m, rows_s;
    logic [3:0]      pat, pat_nxt;
    logic [TW-1:0]   tick_cnt;
    logic [DW-1:0]   deb_cnt, deb_nxt, deb_inc;
    logic [1:0]      col_nxt;
    logic [3:0]      code_nxt;
    logic            valid_nxt;
    logic            sample;

    // Multiple rows on one column: the lowest row index wins.
    function automatic logic [1:0] low_row(input logic [3:0] p);
        low_row = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (p[i]) low_row = 2'(i);
        end
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows_m   <= 4'b0000;
            rows_s   <= 4'b0000;
            tick_cnt <= '0;
        end else begin
            rows_m   <= row_in;
            rows_s   <= rows_m;
            tick_cnt <= sample ? '0 : tick_cnt + TW'(1);
        end
    end

    assign sample   = (tick_cnt == TICK_LAST);
    assign deb_inc  = deb_cnt + DW'(1);
    assign key_held = (state == HOLD) || (state == RELEASE);

    // key_valid is a single-cycle, unacknowledged pulse: key_code is valid in that same
    // cycle and stays stable until the next accepted press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SCAN;
            col_sel   <= 2'd0;
            pat       <= 4'b0000;
            deb_cnt   <= '0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            col_sel   <= col_nxt;
            pat       <= pat_nxt;
            deb_cnt   <= deb_nxt;
            key_code  <= code_nxt;
            key_valid <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        col_nxt   = col_sel;
        pat_nxt   = pat;
        deb_nxt   = deb_cnt;
        code_nxt  = key_code;
        valid_nxt = 1'b0;
        if (sample) begin
            case (state)
                SCAN: begin
                    if (rows_s == 4'b0000) begin
                        col_nxt = col_sel + 2'd1;
                    end else begin
                        pat_nxt = rows_s;
                        deb_nxt = DW'(1);
                        if (DEB_SAMPLES == 1) begin
                            valid_nxt = 1'b1;
                            code_nxt  = {low_row(rows_s), col_sel};
                            deb_nxt   = '0;
                            state_nxt = HOLD;
                        end else begin
                            state_nxt = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (rows_s == pat) begin
                        deb_nxt = deb_inc;
                        if (deb_inc == DEB_LAST) begin
                            valid_nxt = 1'b1;
                            code_nxt  = {low_row(pat), col_sel};
                            deb_nxt   = '0;
                            state_nxt = HOLD;
                        end
                    end else begin
                        // A bounce or changed combination abandons the press and moves on.
                        deb_nxt   = '0;
                        col_nxt   = col_sel + 2'd1;
                        state_nxt = SCAN;
                    end
                end
                HOLD: begin
                    if (rows_s == 4'b0000) begin
                        if (DEB_SAMPLES == 1) begin
                            deb_nxt   = '0;
                            col_nxt   = col_sel + 2'd1;
                            state_nxt = SCAN;
                        end else begin
                            deb_nxt   = DW'(1);
                            state_nxt = RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (rows_s != 4'b0000) begin
                        deb_nxt   = '0;
                        state_nxt = HOLD;
                    end else if (deb_inc == DEB_LAST) begin
                        deb_nxt   = '0;
                        col_nxt   = col_sel + 2'd1;
                        state_nxt = SCAN;
                    end else begin
                        deb_nxt = deb_inc;
                    end
                end
                default: state_nxt = SCAN;
            endcase
        end
    end

endmodule
